// File: rtl/led_event_scheduler.sv
// led_event_scheduler
//
// Shares one status LED between N_REQ event requesters. A rising edge on a
// request line latches a pending bit. A round-robin arbiter then picks one
// pending requester at a time. Requester k is shown as k+1 blinks, each
// ON_CYCLES lit and OFF_CYCLES dark, followed by a GAP_CYCLES dark gap.
//
// Ports
//   i_clk      system clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_req      asynchronous request lines, one per requester, rising-edge sensitive
//   i_enable   permits new grants (an in-flight burst always completes)
//   o_led      registered LED drive
//   o_grant    one-hot requester in service, zero when idle
//   o_pending  latched requests not yet granted
//   o_busy     high whenever the sequencer is not idle
//   o_done     one-cycle pulse when a service finishes
//
// state | meaning
// IDLE  | waiting for enable and a pending request
// ARB   | one cycle: pick the next requester, load the blink count
// ON    | LED lit for ON_CYCLES
// OFF   | LED dark for OFF_CYCLES, then next blink or gap
// GAP   | LED dark for GAP_CYCLES before returning to IDLE

module led_event_scheduler #(
    parameter int N_REQ      = 4,
    parameter int ON_CYCLES  = 5000000,
    parameter int OFF_CYCLES = 5000000,
    parameter int GAP_CYCLES = 50000000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_enable,
    output logic             o_led,
    output logic [N_REQ-1:0] o_grant,
    output logic [N_REQ-1:0] o_pending,
    output logic             o_busy,
    output logic             o_done
);

    localparam int MAX_ON_OFF = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int MAX_CYC    = (MAX_ON_OFF > GAP_CYCLES) ? MAX_ON_OFF : GAP_CYCLES;
    localparam int TW         = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int LW         = $clog2(N_REQ);
    localparam int BW         = $clog2(N_REQ + 1);

    // The timer counts down to zero, so each phase loads its length minus one.
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ON,
        OFF,
        GAP
    } state_t;

    state_t            state;
    logic [TW-1:0]     timer;
    logic [BW-1:0]     blinks;
    logic [LW-1:0]     last_grant;

    logic [N_REQ-1:0]  sync1;
    logic [N_REQ-1:0]  sync2;
    logic [N_REQ-1:0]  sync3;
    logic [N_REQ-1:0]  armed;
    logic [1:0]        sync_vld;
    logic [N_REQ-1:0]  rise;
    logic [N_REQ-1:0]  pending;

    logic [LW-1:0]     pick_idx;
    logic [N_REQ-1:0]  pick_onehot;
    logic [N_REQ-1:0]  grant_clr;

    // An edge is only accepted after the synchronized line has been seen low
    // following reset. A line held high through reset therefore never
    // produces a request. sync_vld marks when sync2 holds a real sample
    // rather than its reset value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            sync3    <= '0;
            armed    <= '0;
            sync_vld <= '0;
        end else begin
            sync1    <= i_req;
            sync2    <= sync1;
            sync3    <= sync2;
            sync_vld <= {sync_vld[0], 1'b1};
            if (sync_vld[1]) begin
                armed <= armed | ~sync2;
            end
        end
    end

    assign rise = sync2 & ~sync3 & armed;

    // First pending index after last_grant, wrapping modulo N_REQ.
    function automatic logic [LW-1:0] rr_pick(input logic [N_REQ-1:0] p,
                                              input logic [LW-1:0]    last);
        int            c;
        logic [LW-1:0] ci;
        logic [LW-1:0] r;
        logic          found;
        r     = '0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            c = int'(last) + i;
            if (c >= N_REQ) begin
                c = c - N_REQ;
            end
            ci = c[LW-1:0];
            if (!found && p[ci]) begin
                r     = ci;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign pick_idx    = rr_pick(pending, last_grant);
    assign pick_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
    assign grant_clr   = (state == ARB) ? pick_onehot : '0;

    // A new edge on the requester being granted is kept (set wins over clear).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~grant_clr) | rise;
        end
    end

    assign o_pending = pending;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            blinks     <= '0;
            last_grant <= LW'(N_REQ - 1);
            o_led      <= 1'b0;
            o_grant    <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_enable && (|pending)) begin
                        state  <= ARB;
                        timer  <= '0;
                        o_busy <= 1'b1;
                    end
                end
                ARB: begin
                    state      <= ON;
                    o_grant    <= pick_onehot;
                    last_grant <= pick_idx;
                    blinks     <= BW'(pick_idx) + BW'(1);
                    timer      <= ON_LOAD;
                    o_led      <= 1'b1;
                end
                ON: begin
                    if (timer == '0) begin
                        state <= OFF;
                        timer <= OFF_LOAD;
                        o_led <= 1'b0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                OFF: begin
                    if (timer == '0) begin
                        blinks <= blinks - BW'(1);
                        if (blinks != BW'(1)) begin
                            state <= ON;
                            timer <= ON_LOAD;
                            o_led <= 1'b1;
                        end else begin
                            state <= GAP;
                            timer <= GAP_LOAD;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                GAP: begin
                    if (timer == '0) begin
                        state   <= IDLE;
                        timer   <= '0;
                        o_grant <= '0;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
